// File: rtl/apb_cmd_master_if.sv
// Command/response stream and APB3 bus bundle for apb_cmd_master.
// The master modport is the view of the command master itself; the slave
// modport is the view of whatever sits around it (sequencer plus APB target).
interface apb_cmd_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_slverr;
    logic              rsp_timeout;

    // APB3 bus
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB3 master stage: turns one valid/ready command into a single APB transfer
// and hands the result back on a valid/ready response channel. One transfer
// in flight at a time; an optional pready wait limit aborts a stuck slave.
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             pclk,
    input  logic             preset,
    apb_cmd_master_if.master bus
);
    // counter must hold TIMEOUT_CYCLES itself without wrapping
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_slverr_q;
    logic              rsp_timeout_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  wait_cnt_inc;

    logic              cmd_fire;
    logic              timeout_hit;
    logic              cmd_ready_d;
    logic              psel_d;
    logic              penable_d;
    logic              rsp_valid_d;

    assign cmd_fire     = (state == ST_IDLE) && bus.cmd_valid;
    assign wait_cnt_inc = wait_cnt + CNT_W'(1);
    // this pready-low ACCESS cycle is the TIMEOUT_CYCLES-th in a row
    assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (wait_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    // state register; reset abandons any transfer in flight
    always_ff @(posedge pclk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (preset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // next-state and state-decoded control outputs
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        state_nxt   = state;
        cmd_ready_d = 1'b0;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid) state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                psel_d    = 1'b1;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                if (bus.pready || timeout_hit) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                if (bus.rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // command latch, response capture and pready wait counter
    always_ff @(posedge pclk) begin
        if (preset) begin
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            if (cmd_fire) begin
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_wdata;
                pwrite_q <= bus.cmd_write;
                wait_cnt <= '0;
            end
            if (state == ST_ACCESS) begin
                if (bus.pready) begin
                    rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
                    rsp_slverr_q  <= bus.pslverr;
                    rsp_timeout_q <= 1'b0;
                end else begin
                    // with no limit configured the counter is left alone
                    if (TIMEOUT_CYCLES != 0) wait_cnt <= wait_cnt_inc;
                    if (timeout_hit) begin
                        rsp_rdata_q   <= '0;
                        rsp_slverr_q  <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_d;
    assign bus.psel        = psel_d;
    assign bus.penable     = penable_d;
    assign bus.rsp_valid   = rsp_valid_d;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: directed cases followed by random
// transactions, each predicted from the transfer rules (wait count versus
// timeout limit, direction, slave error) rather than from the design's FSM.
module tb_apb_cmd_master;
    localparam int TO = 8;

    logic pclk = 1'b0;
    logic preset;
    int   checks = 0;
    int   errors = 0;

    apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_cmd_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus.master)
    );

    // free-running clock
    always #5 pclk = ~pclk;

    // advance past the next rising edge and settle
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // slave outputs outside ACCESS must be ignored, so make them noise
    task automatic slave_noise();
        bus.pready  = 1'($urandom);
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom);
    endtask

    // command inputs while cmd_ready=0 must be ignored, so make them noise
    task automatic cmd_noise();
        bus.cmd_valid = 1'($urandom);
        bus.cmd_write = 1'($urandom);
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
    endtask

    // One complete command: slave holds pready low for `waits` ACCESS cycles,
    // then returns rd/err; response is held `rsp_delay` cycles before consume.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rd, input logic err,
                          input int rsp_delay);
        logic        exp_to;
        int          n_access;
        logic [31:0] exp_rdata;
        logic        exp_err;

        // reference: abort if the slave would still be waiting on the TO-th cycle
        exp_to    = (waits >= TO);
        n_access  = exp_to ? TO : waits + 1;
        exp_rdata = (wr || exp_to) ? 32'h0 : rd;
        exp_err   = exp_to ? 1'b1 : err;

        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.rsp_ready = 1'b0;
        slave_noise();
        check("idle_cmd_ready", bus.cmd_ready, 1'b1);
        tick();

        // SETUP
        cmd_noise();
        slave_noise();
        check("setup_psel", bus.psel, 1'b1);
        check("setup_penable", bus.penable, 1'b0);
        check("setup_paddr", bus.paddr, addr);
        check("setup_pwrite", bus.pwrite, wr);
        check("setup_pwdata", bus.pwdata, wdata);
        check("setup_cmd_ready", bus.cmd_ready, 1'b0);
        tick();

        // ACCESS cycles
        for (int c = 0; c < n_access; c++) begin
            check("access_psel", bus.psel, 1'b1);
            check("access_penable", bus.penable, 1'b1);
            check("access_paddr", bus.paddr, addr);
            check("access_pwrite", bus.pwrite, wr);
            check("access_pwdata", bus.pwdata, wdata);
            check("access_rsp_valid", bus.rsp_valid, 1'b0);
            cmd_noise();
            bus.pready  = (c == waits);
            bus.prdata  = (c == waits) ? rd : $urandom;
            bus.pslverr = (c == waits) ? err : 1'($urandom);
            tick();
        end

        // RESP, possibly stalled
        for (int d = 0; d <= rsp_delay; d++) begin
            check("resp_valid", bus.rsp_valid, 1'b1);
            check("resp_psel", bus.psel, 1'b0);
            check("resp_penable", bus.penable, 1'b0);
            check("resp_cmd_ready", bus.cmd_ready, 1'b0);
            check("resp_rdata", bus.rsp_rdata, exp_rdata);
            check("resp_slverr", bus.rsp_slverr, exp_err);
            check("resp_timeout", bus.rsp_timeout, exp_to);
            cmd_noise();
            slave_noise();
            bus.rsp_ready = (d == rsp_delay);
            tick();
        end

        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check("post_rsp_valid", bus.rsp_valid, 1'b0);
        check("post_cmd_ready", bus.cmd_ready, 1'b1);
    endtask

    // directed sequence followed by random traffic
    initial begin
        preset        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;
        tick();
        tick();

        check("rst_psel", bus.psel, 1'b0);
        check("rst_penable", bus.penable, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_paddr", bus.paddr, 32'h0);
        check("rst_pwdata", bus.pwdata, 32'h0);
        check("rst_pwrite", bus.pwrite, 1'b0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_slverr", bus.rsp_slverr, 1'b0);
        check("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
        preset = 1'b0;

        // plain write, zero wait
        do_txn(1'b1, 32'h0000_0000, 32'h0000_0001, 0, 32'h0, 1'b0, 0);
        // read with three wait states
        do_txn(1'b0, 32'h0000_000C, 32'h0, 3, 32'h0000_002A, 1'b0, 0);
        // pready stuck low: timeout
        do_txn(1'b0, 32'h0000_0010, 32'h0, 1000, 32'hDEAD_BEEF, 1'b0, 0);
        // boundary: ready on the last allowed cycle, and one wait too many
        do_txn(1'b0, 32'h0000_0014, 32'h0, TO - 1, 32'h1234_5678, 1'b0, 0);
        do_txn(1'b0, 32'h0000_0018, 32'h0, TO, 32'h1234_5678, 1'b0, 0);
        // slave error on write
        do_txn(1'b1, 32'h0000_0004, 32'hCAFE_F00D, 0, 32'h0, 1'b1, 0);
        // response back-pressure for five cycles, then back-to-back command
        do_txn(1'b0, 32'h0000_0008, 32'h0, 1, 32'h0000_0055, 1'b0, 5);
        do_txn(1'b1, 32'h0000_0008, 32'h0000_00AA, 0, 32'h0, 1'b0, 0);

        // reset during ACCESS abandons the transfer
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h0000_0040;
        bus.cmd_wdata = 32'h0000_0077;
        bus.pready    = 1'b0;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        check("pre_rst_penable", bus.penable, 1'b1);
        preset = 1'b1;
        tick();
        preset = 1'b0;
        check("midrst_psel", bus.psel, 1'b0);
        check("midrst_penable", bus.penable, 1'b0);
        check("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        check("midrst_cmd_ready", bus.cmd_ready, 1'b1);
        check("midrst_paddr", bus.paddr, 32'h0);
        tick();
        check("midrst_no_rsp", bus.rsp_valid, 1'b0);
        do_txn(1'b0, 32'h0000_000C, 32'h0, 0, 32'h0000_0003, 1'b0, 0);

        // random traffic
        for (int i = 0; i < 25; i++) begin
            do_txn(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 10)),
                   $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
